// File: rtl/vga_pattern_pkg.sv
// rtl/vga_pattern_pkg.sv - shared types and constants for the VGA test-pattern sequencer
package vga_pattern_pkg;

   typedef enum logic [1:0] {
      VLINE   = 2'd0,
      HLINE   = 2'd1,
      BARS    = 2'd2,
      CHECKER = 2'd3
   } pattern_e;

   localparam logic [9:0] FULL  = 10'h3FF;
   localparam logic [9:0] BLACK = 10'h000;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_V_ACTIVE = 480;

   function automatic pattern_e next_pattern(input pattern_e p);
      return pattern_e'(p + 2'd1);
   endfunction

endpackage

// File: rtl/vga_pattern_sequencer_if.sv
// rtl/vga_pattern_sequencer_if.sv - timing-generator side and DAC side signals of the sequencer
interface vga_pattern_sequencer_if;

   logic [9:0] xPos;
   logic [9:0] yPos;
   logic       frame_start;
   logic       next_req;
   logic       hold;
   logic [9:0] red;
   logic [9:0] green;
   logic [9:0] blue;
   logic [1:0] pattern_id;
   logic [9:0] line_pos;

   modport master (
      output xPos, yPos, frame_start, next_req, hold,
      input  red, green, blue, pattern_id, line_pos
   );

   modport slave (
      input  xPos, yPos, frame_start, next_req, hold,
      output red, green, blue, pattern_id, line_pos
   );

endinterface

// File: rtl/vga_pattern_pixel.sv
// rtl/vga_pattern_pixel.sv - combinational colour of one pixel for the current pattern and sweep position
module vga_pattern_pixel
   import vga_pattern_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int LINE_WIDTH = 10
) (
   input  pattern_e   pattern_i,
   input  logic [9:0] line_pos_i,
   input  logic [9:0] x_i,
   input  logic [9:0] y_i,
   output logic [9:0] red_o,
   output logic [9:0] green_o,
   output logic [9:0] blue_o
);

   logic [10:0] x11, y11, lp11, lp_end;
   logic        active, in_vline, in_hline;
   logic [2:0]  bar_idx;

   // 11-bit so line_pos+LINE_WIDTH cannot wrap near the right/bottom edge
   always_comb begin
      x11      = {1'b0, x_i};
      y11      = {1'b0, y_i};
      lp11     = {1'b0, line_pos_i};
      lp_end   = lp11 + 11'(LINE_WIDTH);
      active   = (x11 < 11'(H_ACTIVE)) && (y11 < 11'(V_ACTIVE));
      in_vline = (lp11 <= x11) && (x11 < lp_end);
      in_hline = (lp11 <= y11) && (y11 < lp_end);
      bar_idx  = x_i[8:6];
   end

   always_comb begin
      red_o   = BLACK;
      green_o = BLACK;
      blue_o  = BLACK;
      if (active) begin
         unique case (pattern_i)
            VLINE:   if (in_vline) {red_o, green_o, blue_o} = {FULL, FULL, FULL};
            HLINE:   if (in_hline) {red_o, green_o, blue_o} = {FULL, FULL, FULL};
            BARS: begin
               red_o   = bar_idx[2] ? FULL : BLACK;
               green_o = bar_idx[1] ? FULL : BLACK;
               blue_o  = bar_idx[0] ? FULL : BLACK;
            end
            CHECKER: if (x_i[5] ^ y_i[5]) {red_o, green_o, blue_o} = {FULL, FULL, FULL};
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// rtl/vga_pattern_sequencer.sv - cycles four test patterns per frame count or user request and animates the sweep line
module vga_pattern_sequencer
   import vga_pattern_pkg::*;
#(
   parameter int H_ACTIVE           = DEF_H_ACTIVE,
   parameter int V_ACTIVE           = DEF_V_ACTIVE,
   parameter int FRAMES_PER_PATTERN = 120,
   parameter int LINE_WIDTH         = 10,
   parameter int STEP               = 4
) (
   input logic                     vga_clk,
   input logic                     RST,
   vga_pattern_sequencer_if.slave  bus
);

   localparam int CW = ($clog2(FRAMES_PER_PATTERN) > 7) ? $clog2(FRAMES_PER_PATTERN) : 7;

   pattern_e    pattern_q, pattern_d;
   logic [CW-1:0] frame_cnt_q, frame_cnt_d;
   logic [9:0]  line_pos_q, line_pos_d;
   logic        pend_q, pend_d;
   logic [9:0]  red_q, green_q, blue_q;
   logic [9:0]  red_d, green_d, blue_d;
   logic        advance;
   logic [10:0] line_sum;

   always_ff @(posedge vga_clk or negedge RST) begin
      if (!RST) pattern_q <= VLINE;
      else      pattern_q <= pattern_d;
   end

   // A request seen at any point in the frame is honoured at the next frame_start only.
   always_comb begin
      advance = bus.frame_start &&
                (pend_q || bus.next_req ||
                 (!bus.hold && (frame_cnt_q == CW'(FRAMES_PER_PATTERN - 1))));
      pattern_d = advance ? next_pattern(pattern_q) : pattern_q;
   end

   always_comb begin
      pend_d      = bus.frame_start ? 1'b0 : (pend_q | bus.next_req);
      frame_cnt_d = frame_cnt_q;
      line_pos_d  = line_pos_q;
      line_sum    = {1'b0, line_pos_q} + 11'(STEP);
      if (advance) begin
         frame_cnt_d = '0;
         line_pos_d  = '0;
      end else if (bus.frame_start && !bus.hold) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
         unique case (pattern_q)
            VLINE:   line_pos_d = (line_sum > 11'(H_ACTIVE - LINE_WIDTH)) ? 10'd0 : line_sum[9:0];
            HLINE:   line_pos_d = (line_sum > 11'(V_ACTIVE - LINE_WIDTH)) ? 10'd0 : line_sum[9:0];
            default: line_pos_d = '0;
         endcase
      end
   end

   vga_pattern_pixel #(
      .H_ACTIVE   (H_ACTIVE),
      .V_ACTIVE   (V_ACTIVE),
      .LINE_WIDTH (LINE_WIDTH)
   ) u_pixel (
      .pattern_i  (pattern_q),
      .line_pos_i (line_pos_q),
      .x_i        (bus.xPos),
      .y_i        (bus.yPos),
      .red_o      (red_d),
      .green_o    (green_d),
      .blue_o     (blue_d)
   );

   always_ff @(posedge vga_clk or negedge RST) begin
      if (!RST) begin
         frame_cnt_q <= '0;
         line_pos_q  <= '0;
         pend_q      <= 1'b0;
         red_q       <= BLACK;
         green_q     <= BLACK;
         blue_q      <= BLACK;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         line_pos_q  <= line_pos_d;
         pend_q      <= pend_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
      end
   end

   always_comb begin
      bus.red        = red_q;
      bus.green      = green_q;
      bus.blue       = blue_q;
      bus.pattern_id = pattern_q;
      bus.line_pos   = line_pos_q;
   end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb/tb_vga_pattern_sequencer.sv - randomized self-checking bench for vga_pattern_sequencer
module tb_vga_pattern_sequencer;

   localparam int H    = 640;
   localparam int V    = 480;
   localparam int FPP  = 120;
   localparam int LW   = 10;
   localparam int STEP = 4;

   logic vga_clk = 1'b0;
   logic RST;
   always #5 vga_clk = ~vga_clk;

   vga_pattern_sequencer_if bus();

   vga_pattern_sequencer #(
      .H_ACTIVE           (H),
      .V_ACTIVE           (V),
      .FRAMES_PER_PATTERN (FPP),
      .LINE_WIDTH         (LW),
      .STEP               (STEP)
   ) dut (
      .vga_clk (vga_clk),
      .RST     (RST),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   int          m_pat, m_lp, m_cnt;
   bit          m_pend;
   logic [29:0] m_rgb;

   function automatic logic [29:0] ref_pixel(int pat, int lp, int x, int y);
      int idx;
      logic [9:0] r, g, b;
      r = 0; g = 0; b = 0;
      if (x < H && y < V) begin
         case (pat)
            0: if (x >= lp && x < lp + LW) begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
            1: if (y >= lp && y < lp + LW) begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
            2: begin
               idx = (x / 64) % 8;
               if (idx >= 4)           r = 10'h3FF;
               if ((idx / 2) % 2 == 1) g = 10'h3FF;
               if (idx % 2 == 1)       b = 10'h3FF;
            end
            default: if (((x / 32) + (y / 32)) % 2 == 1) begin r = 10'h3FF; g = 10'h3FF; b = 10'h3FF; end
         endcase
      end
      return {r, g, b};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string where);
      chk({where, " red"},        32'(bus.red),        32'(m_rgb[29:20]));
      chk({where, " green"},      32'(bus.green),      32'(m_rgb[19:10]));
      chk({where, " blue"},       32'(bus.blue),       32'(m_rgb[9:0]));
      chk({where, " pattern_id"}, 32'(bus.pattern_id), 32'(m_pat));
      chk({where, " line_pos"},   32'(bus.line_pos),   32'(m_lp));
   endtask

   task automatic model_reset();
      m_pat = 0; m_lp = 0; m_cnt = 0; m_pend = 0; m_rgb = '0;
   endtask

   task automatic cycle(input bit fs, input bit nr, input bit hd, input int x, input int y);
      @(negedge vga_clk);
      bus.frame_start = fs;
      bus.next_req    = nr;
      bus.hold        = hd;
      bus.xPos        = 10'(x);
      bus.yPos        = 10'(y);
      @(posedge vga_clk);
      m_rgb = ref_pixel(m_pat, m_lp, x, y);
      if (fs) begin
         if (m_pend || nr || (!hd && m_cnt == FPP - 1)) begin
            m_pat = (m_pat + 1) % 4; m_cnt = 0; m_lp = 0;
         end else if (!hd) begin
            m_cnt++;
            if (m_pat == 0)      begin m_lp += STEP; if (m_lp > H - LW) m_lp = 0; end
            else if (m_pat == 1) begin m_lp += STEP; if (m_lp > V - LW) m_lp = 0; end
            else m_lp = 0;
         end
         m_pend = 0;
      end else if (nr) begin
         m_pend = 1;
      end
      #1;
      check_all(fs ? "frame_start" : "pixel");
   endtask

   task automatic pix(input int x, input int y, input bit hd);
      cycle(0, 0, hd, x, y);
   endtask

   task automatic frame(input int len, input bit nr_fs, input bit hd, input int req_pct);
      cycle(1, nr_fs, hd, $urandom_range(799), $urandom_range(524));
      for (int i = 0; i < len; i++)
         cycle(0, $urandom_range(99) < req_pct, hd, $urandom_range(799), $urandom_range(524));
   endtask

   initial begin
      RST = 1'b0;
      bus.frame_start = 0; bus.next_req = 0; bus.hold = 0; bus.xPos = 0; bus.yPos = 0;
      model_reset();
      repeat (2) @(posedge vga_clk);
      #1;
      check_all("reset");
      @(negedge vga_clk);
      RST = 1'b1;

      // sweep line 0 -> 4 -> 8 -> 12, probing column 8
      for (int f = 0; f < 4; f++) begin
         pix(8, 100, 0);
         pix(7, 100, 0);
         pix(17, 100, 0);
         cycle(1, 0, 0, 8, 100);
      end

      // long unattended run: auto-advance through all patterns and the HLINE wrap
      repeat (600) frame(2, 0, 0, 0);

      // two mid-frame requests collapse into one advance
      cycle(1, 0, 0, 10, 10);
      pix(20, 20, 0);
      cycle(0, 1, 0, 30, 30);
      pix(40, 40, 0);
      cycle(0, 1, 0, 50, 50);
      cycle(1, 0, 0, 60, 60);
      cycle(1, 0, 0, 60, 60);

      // request coincident with frame_start
      cycle(1, 1, 0, 5, 5);
      pix(6, 6, 0);
      cycle(1, 0, 0, 7, 7);

      // hold freezes motion and auto-advance but not requests
      repeat (10) frame(3, 0, 1, 0);
      frame(3, 1, 1, 0);
      cycle(0, 1, 1, 1, 1);
      frame(3, 0, 1, 0);

      // colour bars and checkerboard
      while (m_pat != 2) cycle(1, 1, 0, 0, 0);
      pix(0, 0, 0);
      pix(448, 10, 0);
      pix(700, 10, 0);
      pix(200, 479, 0);
      pix(100, 480, 0);
      pix(575, 300, 0);
      cycle(1, 1, 0, 0, 0);
      pix(32, 0, 0);
      pix(32, 32, 0);
      pix(0, 0, 0);
      pix(639, 31, 0);

      // randomized mix of frame lengths, requests and hold
      repeat (300) frame($urandom_range(1, 6), $urandom_range(9) == 0, $urandom_range(3) == 0, 10);

      // asynchronous reset in the middle of an HLINE frame with a lit pixel on the outputs
      while (m_pat != 1) cycle(1, 1, 0, 0, 0);
      repeat (5) frame(2, 0, 0, 0);
      pix(5, m_lp, 0);
      #1;
      RST = 1'b0;
      model_reset();
      #1;
      check_all("async_reset");
      @(negedge vga_clk);
      RST = 1'b1;
      repeat (3) frame(3, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
